// File: rtl/equation_pkg.sv
// rtl/equation_pkg.sv - shared types and helpers for the equation builder
package equation_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_OP = 3'd1,
        WAIT_B  = 3'd2,
        EVAL    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    typedef enum logic {
        OP_PLUS  = 1'b0,
        OP_MINUS = 1'b1
    } op_t;

    // Index of the lowest set bit; vectors up to 8 bits wide.
    function automatic logic [2:0] lsb_index(input logic [7:0] vec);
        lsb_index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                lsb_index = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/equation_builder_frame_counter.sv
// rtl/equation_builder_frame_counter.sv - counts startOfFrame pulses up to a limit
module frame_counter
    import equation_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             startOfFrame,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] lim_eff;

    // done fires on the frame pulse that completes the count, so the
    // owner can act on the same edge.
    always_comb begin
        lim_eff = (limit == '0) ? CNT_W'(1) : limit;
        done    = startOfFrame && !clear && (count_q >= (lim_eff - CNT_W'(1)));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else if (clear || done) begin
            count_q <= '0;
        end else if (startOfFrame) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/equation_builder.sv
// rtl/equation_builder.sv - builds "A op B" from hit pulses, scores it; EQUATION_TIMEOUT_EN adds a hit timeout
module equation_builder
    import equation_pkg::*;
#(
    parameter int NUMBERS        = 3,
    parameter int VALUE_W        = 4,
    parameter int RESULT_W       = 8,
    parameter int SCORE_W        = 10,
    parameter int POINTS         = 5,
    parameter int MSG_FRAMES     = 60,
    parameter int TIMEOUT_FRAMES = 150
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUMBERS-1:0]         SingleHitPulse,
    input  logic [1:0]                 operandHit,
    input  logic [NUMBERS*VALUE_W-1:0] numberValues,
    input  logic [RESULT_W-1:0]        target,
    output logic [VALUE_W-1:0]         operandA,
    output logic [VALUE_W-1:0]         operandB,
    output logic                       opSel,
    output logic [RESULT_W-1:0]        result,
    output logic                       resultValid,
    output logic                       correctPulse,
    output logic                       wrongPulse,
    output logic [SCORE_W-1:0]         score,
    output logic [NUMBERS-1:0]         respawnNumber,
    output logic [1:0]                 respawnOperand,
    output logic                       timeoutPulse,
    output logic [2:0]                 stateOut
);

    localparam int MSG_EFF = (MSG_FRAMES < 1) ? 1 : MSG_FRAMES;
    localparam int TO_EFF  = (TIMEOUT_FRAMES < 1) ? 1 : TIMEOUT_FRAMES;
    localparam logic [SCORE_W-1:0] PTS = SCORE_W'(POINTS);

    state_t                state_q, state_d;
    logic [VALUE_W-1:0]    a_q, a_d, b_q, b_d;
    op_t                   op_q, op_d;
    logic [RESULT_W-1:0]   res_q, res_d;
    logic                  correct_q, correct_d, wrong_q, wrong_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [NUMBERS-1:0]    rsp_num_q, rsp_num_d;
    logic [1:0]            rsp_op_q, rsp_op_d;

    logic [2:0]            num_idx, op_idx;
    logic                  num_any, op_any;
    logic [VALUE_W-1:0]    num_val;
    logic [RESULT_W-1:0]   eval_res;
    logic [SCORE_W:0]      score_inc;
    logic [SCORE_W-1:0]    score_up, score_dn;
    logic                  fc_clear, fc_done;
    logic [CNT_W-1:0]      fc_limit;

    always_comb begin
        num_any = |SingleHitPulse;
        op_any  = |operandHit;
        num_idx = lsb_index(8'(SingleHitPulse));
        op_idx  = lsb_index(8'(operandHit));
        num_val = '0;
        for (int i = 0; i < NUMBERS; i++) begin
            if (num_idx == 3'(i)) begin
                num_val = numberValues[i*VALUE_W +: VALUE_W];
            end
        end
    end

    always_comb begin
        eval_res  = (op_q == OP_MINUS) ? (RESULT_W'(a_q) - RESULT_W'(b_q))
                                       : (RESULT_W'(a_q) + RESULT_W'(b_q));
        score_inc = {1'b0, score_q} + {1'b0, PTS};
        score_up  = score_inc[SCORE_W] ? '1 : score_inc[SCORE_W-1:0];
        score_dn  = (score_q < PTS) ? '0 : (score_q - PTS);
    end

    // One counter serves both the SHOW hold and the hit timeout; it is kept
    // clear whenever it is not counting so entry-cycle frame pulses are lost.
`ifdef EQUATION_TIMEOUT_EN
    logic hit_accepted;
    always_comb begin
        hit_accepted = ((state_q == WAIT_OP) || (state_q == WAIT_B)) && (num_any || op_any);
        fc_clear     = !((state_q == SHOW) || (state_q == WAIT_OP) || (state_q == WAIT_B))
                       || hit_accepted;
    end
`else
    always_comb fc_clear = (state_q != SHOW);
`endif

    always_comb fc_limit = (state_q == SHOW) ? CNT_W'(MSG_EFF) : CNT_W'(TO_EFF);

    frame_counter u_frame_counter (
        .clk          (clk),
        .resetN       (resetN),
        .clear        (fc_clear),
        .startOfFrame (startOfFrame),
        .limit        (fc_limit),
        .done         (fc_done)
    );

`ifdef EQUATION_TIMEOUT_EN
    logic timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        score_d   = score_q;
        correct_d = 1'b0;
        wrong_d   = 1'b0;
        rsp_num_d = '0;
        rsp_op_d  = '0;
`ifdef EQUATION_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            WAIT_A: begin
                if (num_any) begin
                    a_d       = num_val;
                    rsp_num_d = NUMBERS'(1) << num_idx;
                    state_d   = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (op_any) begin
                    op_d     = op_t'(op_idx[0]);
                    rsp_op_d = 2'b01 << op_idx[0];
                    state_d  = WAIT_B;
                end else if (num_any) begin
                    a_d       = num_val;
                    rsp_num_d = NUMBERS'(1) << num_idx;
                end
`ifdef EQUATION_TIMEOUT_EN
                else if (fc_done) begin
                    timeout_d = 1'b1;
                    score_d   = score_dn;
                    state_d   = WAIT_A;
                end
`endif
            end
            WAIT_B: begin
                if (num_any) begin
                    b_d       = num_val;
                    rsp_num_d = NUMBERS'(1) << num_idx;
                    state_d   = EVAL;
                end else if (op_any) begin
                    op_d     = op_t'(op_idx[0]);
                    rsp_op_d = 2'b01 << op_idx[0];
                end
`ifdef EQUATION_TIMEOUT_EN
                else if (fc_done) begin
                    timeout_d = 1'b1;
                    score_d   = score_dn;
                    state_d   = WAIT_A;
                end
`endif
            end
            EVAL: begin
                res_d = eval_res;
                if (eval_res == target) begin
                    correct_d = 1'b1;
                    score_d   = score_up;
                end else begin
                    wrong_d = 1'b1;
                    score_d = score_dn;
                end
                state_d = SHOW;
            end
            SHOW: begin
                if (fc_done) begin
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= WAIT_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_PLUS;
            res_q     <= '0;
            score_q   <= '0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            rsp_num_q <= '0;
            rsp_op_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_q     <= res_d;
            score_q   <= score_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            rsp_num_q <= rsp_num_d;
            rsp_op_q  <= rsp_op_d;
        end
    end

`ifdef EQUATION_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign timeoutPulse = timeout_q;
`else
    assign timeoutPulse = 1'b0;
`endif

    assign operandA       = a_q;
    assign operandB       = b_q;
    assign opSel          = op_q;
    assign result         = res_q;
    assign resultValid    = (state_q == SHOW);
    assign correctPulse   = correct_q;
    assign wrongPulse     = wrong_q;
    assign score          = score_q;
    assign respawnNumber  = rsp_num_q;
    assign respawnOperand = rsp_op_q;
    assign stateOut       = state_q;

endmodule

// File: tb/tb_equation_builder.sv
// tb/tb_equation_builder.sv - self-checking bench for equation_builder
module tb_equation_builder;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [2:0]  SingleHitPulse = '0;
    logic [1:0]  operandHit = '0;
    logic [11:0] numberValues = '0;
    logic [7:0]  target = '0;
    logic [3:0]  operandA, operandB;
    logic        opSel;
    logic [7:0]  result;
    logic        resultValid, correctPulse, wrongPulse, timeoutPulse;
    logic [9:0]  score;
    logic [2:0]  respawnNumber;
    logic [1:0]  respawnOperand;
    logic [2:0]  stateOut;

    int compared = 0;
    int mismatched = 0;
    int vals[3];
    int m_score = 0;

    equation_builder #(.TIMEOUT_FRAMES(3)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .SingleHitPulse(SingleHitPulse), .operandHit(operandHit),
        .numberValues(numberValues), .target(target),
        .operandA(operandA), .operandB(operandB), .opSel(opSel),
        .result(result), .resultValid(resultValid),
        .correctPulse(correctPulse), .wrongPulse(wrongPulse),
        .score(score), .respawnNumber(respawnNumber),
        .respawnOperand(respawnOperand), .timeoutPulse(timeoutPulse),
        .stateOut(stateOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_vals(input int v0, input int v1, input int v2, input int tgt);
        vals[0] = v0; vals[1] = v1; vals[2] = v2;
        numberValues = {4'(v2), 4'(v1), 4'(v0)};
        target = 8'(tgt);
    endtask

    task automatic step(input logic [2:0] nm, input logic [1:0] om, input logic sof);
        @(negedge clk);
        SingleHitPulse = nm; operandHit = om; startOfFrame = sof;
        @(posedge clk);
        #1;
        SingleHitPulse = '0; operandHit = '0; startOfFrame = 1'b0;
    endtask

    function automatic int expect_result(input int a, input int op, input int b);
        return (op == 0) ? ((a + b) % 256) : ((a - b + 256) % 256);
    endfunction

    function automatic int score_after(input int s, input bit ok);
        if (ok) return (s + 5 > 1023) ? 1023 : s + 5;
        return (s < 5) ? 0 : s - 5;
    endfunction

    task automatic check_eval(input int a, input int op, input int b);
        int r;
        bit ok;
        r = expect_result(a, op, b);
        ok = (r == int'(target));
        m_score = score_after(m_score, ok);
        chk("eval_result", result, r);
        chk("eval_correct", correctPulse, ok);
        chk("eval_wrong", wrongPulse, !ok);
        chk("eval_score", score, m_score);
        chk("eval_valid", resultValid, 1);
        chk("eval_state", stateOut, 4);
    endtask

    task automatic finish_show();
        for (int i = 1; i <= 60; i++) begin
            step(3'b000, 2'b00, 1'b1);
            if (i == 59) chk("show_hold", stateOut, 4);
        end
        chk("show_exit_state", stateOut, 0);
        chk("show_exit_valid", resultValid, 0);
    endtask

    task automatic run_eq(input int ia, input int op, input int ib, input logic sof_eval);
        step(3'(1 << ia), 2'b00, 1'b0);
        chk("run_rspA", respawnNumber, 1 << ia);
        chk("run_A", operandA, vals[ia]);
        step(3'b000, 2'(1 << op), 1'b0);
        chk("run_rspOp", respawnOperand, 1 << op);
        chk("run_op", opSel, op);
        step(3'(1 << ib), 2'b00, 1'b0);
        chk("run_B", operandB, vals[ib]);
        chk("run_state_eval", stateOut, 3);
        step(3'b000, 2'b00, sof_eval);
        check_eval(vals[ia], op, vals[ib]);
        step(3'b000, 2'b00, 1'b0);
        chk("pulse_one_cycle", {30'd0, correctPulse, wrongPulse}, 0);
        finish_show();
    endtask

    initial begin
        int ia, ib, op, tgt;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", stateOut, 0);
        chk("rst_score", score, 0);
        chk("rst_outputs", {operandA, operandB, opSel, result, resultValid,
                            correctPulse, wrongPulse, respawnNumber, respawnOperand, timeoutPulse}, 0);
        @(negedge clk);
        resetN = 1'b1;

        // 2 - 5 underflows; score saturates at 0
        set_vals(2, 5, 0, 7);
        run_eq(0, 1, 1, 1'b0);
        chk("minus_wrap", result, 8'hFD);
        chk("minus_score_zero", score, 0);

        // 3 + 4 = 7 correct; frame pulse on SHOW entry ignored; hits in SHOW ignored
        set_vals(3, 4, 9, 7);
        step(3'b001, 2'b00, 1'b0);
        chk("t1_rspA", respawnNumber, 3'b001);
        step(3'b000, 2'b01, 1'b0);
        chk("t1_rspOp", respawnOperand, 2'b01);
        step(3'b010, 2'b00, 1'b0);
        chk("t1_rspB", respawnNumber, 3'b010);
        step(3'b000, 2'b00, 1'b1);
        check_eval(3, 0, 4);
        chk("t1_score5", score, 5);
        step(3'b111, 2'b11, 1'b0);
        chk("show_ignore_num", respawnNumber, 0);
        chk("show_ignore_op", respawnOperand, 0);
        chk("show_ignore_A", operandA, 3);
        finish_show();
        chk("hold_result", result, 7);

        // priority and replacement rules
        step(3'b011, 2'b00, 1'b0);
        chk("prio_rsp", respawnNumber, 3'b001);
        chk("prio_A", operandA, 3);
        step(3'b100, 2'b00, 1'b0);
        chk("replaceA", operandA, 9);
        chk("replaceA_rsp", respawnNumber, 3'b100);
        chk("replaceA_state", stateOut, 1);
        step(3'b001, 2'b10, 1'b0);
        chk("opwins_sel", opSel, 1);
        chk("opwins_rspop", respawnOperand, 2'b10);
        chk("opwins_rspnum", respawnNumber, 0);
        chk("opwins_state", stateOut, 2);
        step(3'b000, 2'b01, 1'b0);
        chk("replaceOp_sel", opSel, 0);
        chk("replaceOp_rsp", respawnOperand, 2'b01);
        chk("replaceOp_state", stateOut, 2);
        step(3'b010, 2'b10, 1'b0);
        chk("numwins_B", operandB, 4);
        chk("numwins_rspnum", respawnNumber, 3'b010);
        chk("numwins_rspop", respawnOperand, 0);
        chk("numwins_sel", opSel, 0);
        step(3'b000, 2'b00, 1'b0);
        check_eval(9, 0, 4);
        finish_show();

        // randomized equations
        for (int n = 0; n < 12; n++) begin
            ia = $urandom_range(0, 2);
            ib = $urandom_range(0, 2);
            op = $urandom_range(0, 1);
            set_vals($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 0);
            tgt = ($urandom_range(0, 1) == 1) ? expect_result(vals[ia], op, vals[ib])
                                               : $urandom_range(0, 255);
            target = 8'(tgt);
            run_eq(ia, op, ib, 1'($urandom_range(0, 1)));
        end

        // score saturation at the top
        set_vals(15, 15, 15, 30);
        while (m_score < 1020) run_eq(0, 0, 1, 1'b0);
        chk("score_1020", score, 1020);
        run_eq(2, 0, 1, 1'b0);
        chk("score_sat_top", score, 1023);

`ifdef EQUATION_TIMEOUT_EN
        step(3'b001, 2'b00, 1'b1);
        step(3'b000, 2'b00, 1'b1);
        step(3'b000, 2'b00, 1'b1);
        chk("to_not_yet", timeoutPulse, 0);
        chk("to_wait_state", stateOut, 1);
        step(3'b000, 2'b00, 1'b1);
        m_score = score_after(m_score, 1'b0);
        chk("to_pulse", timeoutPulse, 1);
        chk("to_state", stateOut, 0);
        chk("to_score", score, m_score);
        chk("to_no_rsp", {respawnNumber, respawnOperand}, 0);
        step(3'b000, 2'b00, 1'b0);
        chk("to_one_cycle", timeoutPulse, 0);
`endif

        // asynchronous reset in WAIT_B with a respawn pulse pending
        step(3'b001, 2'b00, 1'b0);
        step(3'b000, 2'b10, 1'b0);
        chk("pre_rst_rsp", respawnOperand, 2'b10);
        #2;
        resetN = 1'b0;
        #1;
        m_score = 0;
        chk("arst_state", stateOut, 0);
        chk("arst_score", score, m_score);
        chk("arst_outputs", {operandA, operandB, opSel, result, resultValid,
                             correctPulse, wrongPulse, respawnNumber, respawnOperand, timeoutPulse}, 0);
        @(negedge clk);
        resetN = 1'b1;
        step(3'b100, 2'b00, 1'b0);
        chk("post_rst_A", operandA, vals[2]);
        chk("post_rst_state", stateOut, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
